// File: rtl/neurotransmitter_sweep_scheduler.sv
// Sweeps the five neurotransmitter subsystems one at a time: one-hot update enable, settle window,
// then commit of that subsystem's 2-bit field into the committed level register.
module neurotransmitter_sweep_scheduler #(
    parameter int          SETTLE_CYCLES = 2,
    parameter int          SWEEP_PERIOD  = 16,
    parameter int          OVR_W         = 4,
    parameter logic [9:0]  RESET_LEVEL   = 10'h155
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    input  logic             force_sweep,
    input  logic             freeze,
    input  logic [9:0]       level_next,
    output logic [9:0]       level_reg,
    output logic [4:0]       update_en,
    output logic             busy,
    output logic             sweep_done,
    output logic [OVR_W-1:0] overrun_cnt
);
    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam int PW = $clog2(SWEEP_PERIOD + 1);

    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

    state_t           state, state_nxt;
    logic [2:0]       ch, ch_nxt;
    logic [SW-1:0]    cnt, cnt_nxt;
    logic [PW-1:0]    pcnt, pcnt_nxt;
    logic             pending, pending_nxt;
    logic [OVR_W-1:0] ovr_nxt;
    logic [9:0]       level_nxt;
    logic [4:0]       upd_nxt;
    logic             busy_nxt, done_nxt;
    logic             wrap_req, req, start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ch          <= '0;
            cnt         <= '0;
            pcnt        <= '0;
            pending     <= 1'b0;
            overrun_cnt <= '0;
            level_reg   <= RESET_LEVEL;
            update_en   <= '0;
            busy        <= 1'b0;
            sweep_done  <= 1'b0;
        end else begin
            state       <= state_nxt;
            ch          <= ch_nxt;
            cnt         <= cnt_nxt;
            pcnt        <= pcnt_nxt;
            pending     <= pending_nxt;
            overrun_cnt <= ovr_nxt;
            level_reg   <= level_nxt;
            update_en   <= upd_nxt;
            busy        <= busy_nxt;
            sweep_done  <= done_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        ch_nxt      = ch;
        cnt_nxt     = cnt;
        pcnt_nxt    = pcnt;
        pending_nxt = pending;
        ovr_nxt     = overrun_cnt;
        level_nxt   = level_reg;

        // Free-running time base, independent of freeze and sweep activity.
        wrap_req = tick && (pcnt == PW'(SWEEP_PERIOD - 1));
        if (tick)
            pcnt_nxt = wrap_req ? '0 : pcnt + PW'(1);

        req   = wrap_req || force_sweep;
        start = (state == IDLE) && !freeze && (req || pending);

        // A fresh request arriving while the queued one is served re-arms the queue slot.
        if (start)
            pending_nxt = pending && req;
        else if (req && !pending)
            pending_nxt = 1'b1;
        else if (req && overrun_cnt != {OVR_W{1'b1}})
            ovr_nxt = overrun_cnt + OVR_W'(1);

        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = SETTLE;
                    ch_nxt    = '0;
                    cnt_nxt   = '0;
                end
            end
            SETTLE: begin
                if (cnt == SW'(SETTLE_CYCLES - 1))
                    state_nxt = SAMPLE;
                else
                    cnt_nxt = cnt + SW'(1);
            end
            SAMPLE: begin
                for (int k = 0; k < 5; k++)
                    if (ch == 3'(k))
                        level_nxt[2*k +: 2] = level_next[2*k +: 2];
                if (ch == 3'd4) begin
                    state_nxt = DONE;
                end else begin
                    state_nxt = SETTLE;
                    ch_nxt    = ch + 3'd1;
                    cnt_nxt   = '0;
                end
            end
            DONE: begin
                state_nxt = IDLE;
                ch_nxt    = '0;
            end
            default: state_nxt = IDLE;
        endcase

        // Outputs are registered from the next state so they stay Moore-style.
        busy_nxt = (state_nxt == SETTLE) || (state_nxt == SAMPLE);
        upd_nxt  = busy_nxt ? (5'b00001 << ch_nxt) : 5'b00000;
        done_nxt = (state_nxt == DONE);
    end
endmodule

// File: tb/tb_neurotransmitter_sweep_scheduler.sv
// Randomized scoreboard bench: a timeline model predicts every output cycle; a forked monitor compares.
module tb_neurotransmitter_sweep_scheduler;
    localparam int SC      = 2;
    localparam int PERIOD  = 16;
    localparam int SP      = SC + 1;
    localparam int SWL     = 5 * SP;
    localparam int OVR_MAX = 15;

    typedef struct packed {
        logic [4:0] upd;
        logic       busy;
        logic       done;
        logic [9:0] lvl;
        logic [3:0] ovr;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick = 1'b0, force_sweep = 1'b0, freeze = 1'b0;
    logic [9:0] level_next = '0;
    logic [9:0] level_reg;
    logic [4:0] update_en;
    logic       busy, sweep_done;
    logic [3:0] overrun_cnt;

    neurotransmitter_sweep_scheduler #(
        .SETTLE_CYCLES(SC), .SWEEP_PERIOD(PERIOD), .OVR_W(4), .RESET_LEVEL(10'h155)
    ) dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .force_sweep(force_sweep), .freeze(freeze),
        .level_next(level_next), .level_reg(level_reg), .update_en(update_en), .busy(busy),
        .sweep_done(sweep_done), .overrun_cnt(overrun_cnt)
    );

    always #5 clk = ~clk;

    exp_t q[$];
    exp_t me;
    int   n_tests = 0, n_fail = 0;
    bit   in_reset = 1'b1;

    // Reference model: time of the accepted sweep plus arithmetic on the offset from it.
    int         m_c, m_pc, m_t0, m_ovr;
    bit         m_pend;
    logic [9:0] m_lvl;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic model_cycle();
        int   off, k;
        bit   wrap, rq, idle;
        exp_t e;
        wrap = tick && (m_pc == PERIOD - 1);
        if (tick) m_pc = wrap ? 0 : m_pc + 1;
        rq = wrap || force_sweep;
        if (m_t0 >= 0) begin
            off = m_c - m_t0;
            if (off >= SP && off <= SWL && off % SP == 0) begin
                k = off / SP - 1;
                m_lvl[2*k +: 2] = level_next[2*k +: 2];
            end
        end
        idle = (m_t0 < 0) || (m_c - m_t0 > SWL + 1);
        if (idle && !freeze && (rq || m_pend)) begin
            m_t0   = m_c;
            m_pend = m_pend && rq;
        end else if (rq && !m_pend) begin
            m_pend = 1'b1;
        end else if (rq && m_ovr < OVR_MAX) begin
            m_ovr++;
        end
        m_c++;
        e     = '0;
        e.lvl = m_lvl;
        e.ovr = 4'(m_ovr);
        if (m_t0 >= 0) begin
            off = m_c - m_t0;
            if (off >= 1 && off <= SWL) begin
                e.busy = 1'b1;
                e.upd  = 5'b00001 << ((off - 1) / SP);
            end else if (off == SWL + 1) begin
                e.done = 1'b1;
            end
        end
        q.push_back(e);
    endtask

    task automatic step(input bit tk, input bit fs, input bit fz, input logic [9:0] ln);
        @(negedge clk);
        tick = tk; force_sweep = fs; freeze = fz; level_next = ln;
        model_cycle();
    endtask

    task automatic reset_for(input int n);
        rst_n = 1'b0; in_reset = 1'b1; q.delete();
        tick = 0; force_sweep = 0; freeze = 0; level_next = '0;
        repeat (n) begin
            @(negedge clk);
            chk("rst_done", 32'(sweep_done), 0);
            chk("rst_upd", 32'(update_en), 0);
        end
        rst_n = 1'b1;
        chk("rst_lvl", 32'(level_reg), 32'h155);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ovr", 32'(overrun_cnt), 0);
        m_c = 0; m_pc = 0; m_t0 = -1; m_pend = 0; m_ovr = 0; m_lvl = 10'h155;
        in_reset = 1'b0;
    endtask

    task automatic iso(input int lo, input int hi, input logic [9:0] want, input string nm);
        step(0, 1, 0, 10'h000);
        for (int i = 1; i <= 18; i++)
            step(0, 0, 0, (i >= lo && i <= hi) ? 10'h3FF : 10'h000);
        chk(nm, 32'(level_reg), 32'(want));
    endtask

    initial begin
        bit fz;
        fork
            forever begin
                @(posedge clk); #1;
                if (!in_reset && q.size() > 0) begin
                    me = q.pop_front();
                    n_tests++;
                    if ({update_en, busy, sweep_done, level_reg, overrun_cnt} !== me) begin
                        n_fail++;
                        $display("FAIL cycle t=%0t got upd=%b busy=%b done=%b lvl=%h ovr=%0d want upd=%b busy=%b done=%b lvl=%h ovr=%0d",
                                 $time, update_en, busy, sweep_done, level_reg, overrun_cnt,
                                 me.upd, me.busy, me.done, me.lvl, me.ovr);
                    end
                end
            end
        join_none

        reset_for(3);
        repeat (4) step(0, 0, 0, 10'($urandom));

        // Single forced sweep with a constant next-level bus.
        step(0, 1, 0, 10'h3A6);
        repeat (20) step(0, 0, 0, 10'h3A6);
        chk("sweep_lvl", 32'(level_reg), 32'h3A6);

        // Field isolation: only the sample cycle of ch1 matters.
        iso(4, 5, 10'h000, "iso_settle");
        iso(6, 6, 10'h00C, "iso_sample");

        // Periodic requests from a tick every cycle.
        repeat (80) step(1, 0, 0, 10'($urandom));

        // Held force request from a clean idle state saturates the overrun counter.
        reset_for(2);
        repeat (20) step(0, 1, 0, 10'($urandom));
        chk("ovr_sat", 32'(overrun_cnt), 15);
        repeat (40) step(0, 0, 0, 10'($urandom));

        // Freeze blocks the start; release starts it; reset during ch2 settle aborts it.
        step(0, 1, 1, 10'h3FF);
        repeat (4) step(0, 0, 1, 10'h3FF);
        step(0, 0, 0, 10'h3FF);
        repeat (6) step(0, 0, 0, 10'h3FF);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("abort_upd", 32'(update_en), 0);
        chk("abort_lvl", 32'(level_reg), 32'h155);
        chk("abort_busy", 32'(busy), 0);
        reset_for(3);

        // Randomized traffic.
        fz = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(31) == 0) fz = ~fz;
            step(1'($urandom), $urandom_range(15) == 0, fz, 10'($urandom));
        end
        repeat (3) step(0, 0, 0, 10'h000);
        @(posedge clk); #2;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
